fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the in-order integer pipeline. It tracks in-flight destination registers in an internal shadow pipeline, from the EX stage through `DEPTH` post-EX stages. It produces per-operand forwarding selects for the instruction in EX, and a load-use stall/bubble decision for the instruction in ID. It sits beside the ID/EX boundary and is driven by decode fields plus global hold/flush.

---
 rtl/fwd_pkg.sv | 25 ++
 rtl/fwd_match.sv | 33 +++
 rtl/fwd_hazard_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit: producer and EX entries,
// the hard-wired zero register default and the forwarding-select width helper.
package fwd_pkg;

  // Register indices are carried zero-extended to this width inside the unit.
  localparam int MAX_REG_AW   = 8;
  localparam int ZERO_REG_DEF = 31;

  typedef struct packed {
    logic [MAX_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } prod_entry_t;

  // EX-stage occupant; its source fields are kept beside it because their count is a module parameter.
  typedef struct packed {
    logic        valid;
    prod_entry_t prod;
  } ex_entry_t;

  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// One EX source operand against the post-EX stages; the youngest (lowest-index)
// matching producer wins.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEL_W = sel_width(DEPTH)
) (
  input  logic                            enable,
  input  logic [MAX_REG_AW-1:0]           rs,
  input  logic [DEPTH:1][MAX_REG_AW-1:0]  stage_rd,
  input  logic [DEPTH:1]                  stage_wr,
  output logic [SEL_W-1:0]                sel
);

  logic [DEPTH:1] hit;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_hit
      assign hit[gi] = enable & stage_wr[gi] & (stage_rd[gi] == rs);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching stage index is left in sel.
  always_comb begin
    sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit[k]) sel = SEL_W'(k);
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit tracking in-flight destinations from EX onward.
// Optional saturating stall/forward counters are enabled by defining FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 2,
  parameter int REG_AW     = 5,
  parameter int ZERO_REG   = ZERO_REG_DEF,
  parameter int LOAD_READY = 2,
  localparam int SEL_W     = sel_width(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              id_valid,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]    id_rs,
  input  logic [NUM_SRC-1:0]                id_rs_used,
  input  logic [REG_AW-1:0]                 id_rd,
  input  logic                              id_regwrite,
  input  logic                              id_is_load,
  input  logic                              pipe_hold,
  input  logic                              flush,
  output logic                              stall,
`ifdef FWD_HAZARD_STATS_EN
  output logic [31:0]                       stat_stall_cnt,
  output logic [31:0]                       stat_fwd_cnt,
`endif
  output logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel
);

  localparam int RW = MAX_REG_AW;

  ex_entry_t                          ex_reg, ex_next;
  logic [NUM_SRC-1:0][REG_AW-1:0]     ex_rs_reg, ex_rs_next;
  logic [NUM_SRC-1:0]                 ex_rs_used_reg, ex_rs_used_next;
  prod_entry_t [DEPTH:1]              stage_reg, stage_next;
  prod_entry_t [DEPTH:0]              prod_all;
  logic [DEPTH:1][RW-1:0]             stage_rd;
  logic [DEPTH:1]                     stage_wr;
  logic [NUM_SRC-1:0][DEPTH:0]        load_hit;
  logic                               hazard;

  assign prod_all[0]   = ex_reg.prod;
  assign stage_next[1] = ex_reg.valid ? ex_reg.prod : '0;

  genvar gi, gp;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
      assign prod_all[gi] = stage_reg[gi];
      assign stage_rd[gi] = stage_reg[gi].rd;
      assign stage_wr[gi] = stage_reg[gi].regwrite;
    end
    for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
      assign stage_next[gi] = stage_reg[gi-1];
    end

    // A load at position p still lacks its data for a consumer entering EX next cycle when p+1 < LOAD_READY.
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      for (gp = 0; gp <= DEPTH; gp++) begin : g_pos
        assign load_hit[gi][gp] = id_rs_used[gi] & prod_all[gp].regwrite & prod_all[gp].is_load
                                  & (prod_all[gp].rd == RW'(id_rs[gi])) & (gp + 1 < LOAD_READY);
      end

      fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
        .enable   (ex_reg.valid & ex_rs_used_reg[gi]),
        .rs       (RW'(ex_rs_reg[gi])),
        .stage_rd (stage_rd),
        .stage_wr (stage_wr),
        .sel      (fwd_sel[gi])
      );
    end
  endgenerate

  assign hazard = |load_hit;
  assign stall  = id_valid & hazard & ~flush & ~pipe_hold;

  // Zero-register writes are dropped here so no later stage ever sees them as producers.
  always_comb begin
    ex_next         = '0;
    ex_rs_next      = id_rs;
    ex_rs_used_next = '0;
    if (!(flush || stall)) begin
      ex_next.valid         = id_valid;
      ex_next.prod.rd       = RW'(id_rd);
      ex_next.prod.regwrite = id_valid & id_regwrite & (id_rd != REG_AW'(ZERO_REG));
      ex_next.prod.is_load  = id_valid & id_is_load;
      ex_rs_used_next       = id_valid ? id_rs_used : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_reg         <= '0;
      ex_rs_reg      <= '0;
      ex_rs_used_reg <= '0;
      stage_reg      <= '0;
    end else if (!pipe_hold) begin
      ex_reg         <= ex_next;
      ex_rs_reg      <= ex_rs_next;
      ex_rs_used_reg <= ex_rs_used_next;
      stage_reg      <= stage_next;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg, fwd_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      fwd_cnt_reg   <= '0;
    end else begin
      if (stall && (stall_cnt_reg != '1)) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (!pipe_hold && (|fwd_sel) && (fwd_cnt_reg != '1)) fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
    end
  end

  assign stat_stall_cnt = stall_cnt_reg;
  assign stat_fwd_cnt   = fwd_cnt_reg;
`endif

endmodule
